// File: rtl/seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_pkg : active-low 7-segment glyph constants, bit order {g,f,e,d,c,b,a} |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package seg_pkg;

   localparam logic [6:0] c_seg_blank = 7'h7F;

   // Index n holds the glyph for hex digit n (0-9, A, b, C, d, E, F).
   localparam logic [15:0][6:0] c_seg_glyphs = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_hex_decoder : combinational 4-bit nibble to active-low 7-seg glyph    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg_hex_decoder
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] glyph_o
);

   assign glyph_o = c_seg_glyphs[nibble_i];

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_display : multiplexed hex 7-seg driver with PWM brightness and   |
// | frame-synchronous commit. SEG_SCAN_LZB_EN enables leading-zero blanking.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 5000,
   parameter int PWM_BITS   = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [4*NUM_DIGITS-1:0] wr_data,
   input  logic [NUM_DIGITS-1:0]   wr_dp,
   input  logic [PWM_BITS-1:0]     bright,
   output logic [NUM_DIGITS-1:0]   led_en,
   output logic [6:0]              seg,
   output logic                    led_dp,
   output logic                    frame_tick,
   output logic                    pending
);

   localparam int PHASE_LEN = SCAN_DIV >> PWM_BITS;
   localparam int PCW       = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
   localparam int IW        = $clog2(NUM_DIGITS);

   localparam logic [PCW-1:0]        c_phase_cnt_last = PCW'(PHASE_LEN - 1);
   localparam logic [PWM_BITS-1:0]   c_phase_last     = '1;
   localparam logic [IW-1:0]         c_idx_last       = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] c_one_hot0       = NUM_DIGITS'(1);

   // Slot position is tracked as (phase, cycle-within-phase) so that PWM
   // phase needs no divider when the phase length is not a power of two.
   logic [PCW-1:0]          pcnt_q, pcnt_d;
   logic [PWM_BITS-1:0]     phase_q, phase_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shd_data_q, shd_data_d, act_data_q, act_data_d;
   logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
   logic                    pending_q, pending_d;
   logic [NUM_DIGITS-1:0]   led_en_q, led_en_d;
   logic [6:0]              seg_q, seg_d;
   logic                    led_dp_q, led_dp_d;

   logic       slot_end;
   logic       frame_wrap;
   logic       lit;
   logic [3:0] cur_nib;
   logic       cur_dp;
   logic       cur_blank;
   logic [6:0] cur_glyph;

   always_comb begin
      slot_end   = (pcnt_q == c_phase_cnt_last) && (phase_q == c_phase_last);
      frame_wrap = slot_end && (idx_q == c_idx_last);

      pcnt_d  = (pcnt_q == c_phase_cnt_last) ? '0 : pcnt_q + 1'b1;
      phase_d = phase_q;
      if (pcnt_q == c_phase_cnt_last) begin
         phase_d = phase_q + 1'b1;
      end
      idx_d = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
      end
   end

   // A write landing on the wrap cycle bypasses the shadow and commits directly.
   always_comb begin
      shd_data_d = shd_data_q;
      shd_dp_d   = shd_dp_q;
      act_data_d = act_data_q;
      act_dp_d   = act_dp_q;
      pending_d  = pending_q;
      if (wr_en) begin
         shd_data_d = wr_data;
         shd_dp_d   = wr_dp;
         pending_d  = 1'b1;
      end
      if (frame_wrap) begin
         pending_d  = 1'b0;
         act_data_d = wr_en ? wr_data : shd_data_q;
         act_dp_d   = wr_en ? wr_dp   : shd_dp_q;
      end
   end

   always_comb begin
      cur_nib = '0;
      cur_dp  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_nib = act_data_q[4*i +: 4];
            cur_dp  = act_dp_q[i];
         end
      end
   end

`ifdef SEG_SCAN_LZB_EN
   logic [IW-1:0] msd;

   // Digits above the highest non-zero nibble are blanked; digit 0 never is.
   always_comb begin
      msd = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (act_data_q[4*i +: 4] != 4'h0) begin
            msd = IW'(i);
         end
      end
      cur_blank = (idx_q > msd);
   end
`else
   assign cur_blank = 1'b0;
`endif

   seg_hex_decoder u_hex_decoder (
      .nibble_i (cur_nib),
      .glyph_o  (cur_glyph)
   );

   assign lit = (phase_q <= bright);

   always_comb begin
      led_en_d = '1;
      seg_d    = c_seg_blank;
      led_dp_d = 1'b1;
      if (lit) begin
         led_en_d = ~(c_one_hot0 << idx_q);
         seg_d    = cur_blank ? c_seg_blank : cur_glyph;
         led_dp_d = ~cur_dp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q     <= '0;
         phase_q    <= '0;
         idx_q      <= '0;
         shd_data_q <= '0;
         shd_dp_q   <= '0;
         act_data_q <= '0;
         act_dp_q   <= '0;
         pending_q  <= 1'b0;
         led_en_q   <= '1;
         seg_q      <= c_seg_blank;
         led_dp_q   <= 1'b1;
      end else begin
         pcnt_q     <= pcnt_d;
         phase_q    <= phase_d;
         idx_q      <= idx_d;
         shd_data_q <= shd_data_d;
         shd_dp_q   <= shd_dp_d;
         act_data_q <= act_data_d;
         act_dp_q   <= act_dp_d;
         pending_q  <= pending_d;
         led_en_q   <= led_en_d;
         seg_q      <= seg_d;
         led_dp_q   <= led_dp_d;
      end
   end

   assign led_en     = led_en_q;
   assign seg        = seg_q;
   assign led_dp     = led_dp_q;
   assign frame_tick = frame_wrap;
   assign pending    = pending_q;

endmodule
`default_nettype wire

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter SCAN_DIV, default 5000, clk cycles per digit slot; must be a multiple of 2**PWM_BITS.
REQ-003 SHALL have parameter PWM_BITS, default 3, brightness resolution.
REQ-004 SHALL have port clk  in  1  system clock, rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  in  1  write strobe, one beat per cycle.
REQ-007 SHALL have port wr_data  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i.
REQ-008 SHALL have port wr_dp  in  NUM_DIGITS  decimal-point mask, bit i lights DP of digit i; captured with wr_data.
REQ-009 SHALL have port bright  in  PWM_BITS  brightness level, sampled continuously.
REQ-010 SHALL have port led_en  out  NUM_DIGITS  digit enables, active-low, registered.
REQ-011 SHALL have port seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 SHALL have port led_dp  out  1  decimal point, active-low, registered.
REQ-013 SHALL have port frame_tick  out  1  one-cycle pulse at each frame wrap.
REQ-014 SHALL have port pending  out  1  high while a written value awaits frame-boundary commit.

Function
REQ-015 SHALL count slot_cnt 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and digit index idx advances by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-016 SHALL pulse frame_tick for exactly the cycle in which idx wraps NUM_DIGITS-1 -> 0.
REQ-017 SHALL split each slot into 2**PWM_BITS equal phases of SCAN_DIV>>PWM_BITS cycles; digit lit only in phases 0..bright (bright = max gives 100% on, bright = 0 gives 1/2**PWM_BITS).
REQ-018 SHALL drive, one cycle after slot_cnt/idx state, led_en with only bit idx low while lit, all ones while unlit.
REQ-019 SHALL drive seg with the hex glyph of active nibble idx (0-9, A, b, C, d, E, F) and led_dp low when active DP bit idx is set; seg = 7'h7F and led_dp = 1 while unlit.
REQ-020 SHALL load wr_data/wr_dp into a shadow register on wr_en and set pending.
REQ-021 SHALL copy shadow to active registers and clear pending in the frame_tick cycle; display never shows a mix of old and new values within a frame.
REQ-022 SHALL, when wr_en coincides with frame_tick, commit the new wr_data directly to active and leave pending low.
REQ-023 SHALL, on multiple writes before a boundary, commit only the last write.
REQ-024 SHALL apply bright changes from the next cycle without waiting for a frame boundary.

Reset
REQ-025 SHALL on rst_n low asynchronously force led_en all ones, seg 7'h7F, led_dp 1, frame_tick 0, pending 0.
REQ-026 SHALL reset slot_cnt, idx, shadow and active registers to 0; first lit digit after reset release is digit 0 showing "0".
REQ-027 SHALL discard any pending write on reset mid-frame.

Configuration
REQ-028 SHALL implement leading-zero blanking when macro SEG_SCAN_LZB_EN is defined: digits above the most significant non-zero active nibble show seg 7'h7F (DP still honoured); digit 0 always shows its glyph.
REQ-029 SHALL, without SEG_SCAN_LZB_EN, display every digit's glyph including leading zeros.

Structure
REQ-030 SHALL place the 16 segment glyph constants and the blank constant in shared package seg_pkg.
REQ-031 SHALL instantiate sub-module seg_hex_decoder (4-bit nibble -> 7-bit active-low glyph, combinational) for the selected digit.

Verification (NUM_DIGITS=4, SCAN_DIV=8, PWM_BITS=2 unless stated)
REQ-032 SHALL check reset: rst_n low mid-frame -> led_en 4'hF, seg 7'h7F, led_dp 1, pending 0 next sample; after release digit 0 lit with seg 7'h40 within 2 cycles.
REQ-033 SHALL check scan: bright=3, active 16'h1A2F -> led_en sequence E,D,B,7 each 8 cycles, seg 7'h0E,7'h24,7'h08,7'h79; frame_tick every 32 cycles.
REQ-034 SHALL check PWM: bright=1 -> each digit low on led_en exactly 4 of 8 slot cycles; bright=0 -> 2 of 8.
REQ-035 SHALL check commit: wr_en with 16'h1234 mid-frame -> pending 1, old value shown until frame_tick, then 16'h1234 and pending 0; second write 16'h5678 before boundary -> only 5678 ever shown.
REQ-036 SHALL check coincidence: wr_en in frame_tick cycle -> pending stays 0, new value shown from digit 0 of next frame.
REQ-037 SHALL check SEG_SCAN_LZB_EN: active 16'h0050, wr_dp 4'b1000 -> digits 3 and 2 segment-blank, digit 3 DP low, digits 1,0 show "5","0"; macro off -> digits 3,2 show "0".
